// File: rtl/piece_mover.sv
// Active-piece movement controller: turns spawn/move commands into candidate placements,
// asks the collision checker, then commits, rejects, locks or reports a failed spawn.
module piece_mover (
  input  logic        clk,
  input  logic        rst,
  input  logic        spawn,
  input  logic [0:15] spawn_pattern,
  input  logic [3:0]  spawn_x,
  input  logic [4:0]  spawn_y,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd,
  output logic [3:0]  chk_x,
  output logic [4:0]  chk_y,
  output logic [0:15] chk_float,
  input  logic        collision,
  output logic [3:0]  pos_x,
  output logic [4:0]  pos_y,
  output logic [0:15] float,
  output logic        active,
  output logic        move_done,
  output logic        move_ok,
  output logic        lock,
  output logic        spawn_fail
);

  typedef enum logic [1:0] {IDLE, READY, CHECK, EVAL} state_t;
  typedef enum logic [2:0] {OP_LEFT, OP_RIGHT, OP_DOWN, OP_ROT, OP_SPAWN} op_t;

  state_t      state, state_nxt;
  op_t         op, op_nxt;
  logic [3:0]  chk_x_nxt, pos_x_nxt;
  logic [4:0]  chk_y_nxt, pos_y_nxt;
  logic [0:15] chk_float_nxt, float_nxt, rot;
  logic        active_nxt, move_done_nxt, move_ok_nxt, lock_nxt, spawn_fail_nxt;

  // Clockwise rotation of the committed 4x4 pattern.
  for (genvar r = 0; r < 4; r++) begin : g_row
    for (genvar c = 0; c < 4; c++) begin : g_col
      assign rot[r*4+c] = float[c*4+(3-r)];
    end
  end

  assign cmd_ready = (state == READY);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      op         <= OP_LEFT;
      chk_x      <= '0;
      chk_y      <= '0;
      chk_float  <= '0;
      pos_x      <= '0;
      pos_y      <= '0;
      float      <= '0;
      active     <= 1'b0;
      move_done  <= 1'b0;
      move_ok    <= 1'b0;
      lock       <= 1'b0;
      spawn_fail <= 1'b0;
    end else begin
      state      <= state_nxt;
      op         <= op_nxt;
      chk_x      <= chk_x_nxt;
      chk_y      <= chk_y_nxt;
      chk_float  <= chk_float_nxt;
      pos_x      <= pos_x_nxt;
      pos_y      <= pos_y_nxt;
      float      <= float_nxt;
      active     <= active_nxt;
      move_done  <= move_done_nxt;
      move_ok    <= move_ok_nxt;
      lock       <= lock_nxt;
      spawn_fail <= spawn_fail_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    op_nxt         = op;
    chk_x_nxt      = chk_x;
    chk_y_nxt      = chk_y;
    chk_float_nxt  = chk_float;
    pos_x_nxt      = pos_x;
    pos_y_nxt      = pos_y;
    float_nxt      = float;
    active_nxt     = active;
    move_done_nxt  = 1'b0;
    move_ok_nxt    = 1'b0;
    lock_nxt       = 1'b0;
    spawn_fail_nxt = 1'b0;
    case (state)
      IDLE: begin
        if (spawn) begin
          chk_x_nxt     = spawn_x;
          chk_y_nxt     = spawn_y;
          chk_float_nxt = spawn_pattern;
          op_nxt        = OP_SPAWN;
          state_nxt     = CHECK;
        end
      end
      READY: begin
        if (cmd_valid) begin
          chk_x_nxt     = pos_x;
          chk_y_nxt     = pos_y;
          chk_float_nxt = float;
          op_nxt        = op_t'({1'b0, cmd});
          // Off-board wraps (0-1) are left for the checker to reject.
          case (cmd)
            2'b00:   chk_x_nxt     = pos_x - 4'd1;
            2'b01:   chk_x_nxt     = pos_x + 4'd1;
            2'b10:   chk_y_nxt     = pos_y - 5'd1;
            default: chk_float_nxt = rot;
          endcase
          state_nxt = CHECK;
        end
      end
      CHECK: state_nxt = EVAL;
      EVAL: begin
        move_done_nxt = 1'b1;
        if (!collision) begin
          pos_x_nxt   = chk_x;
          pos_y_nxt   = chk_y;
          float_nxt   = chk_float;
          move_ok_nxt = 1'b1;
          active_nxt  = 1'b1;
          state_nxt   = READY;
        end else if (op == OP_DOWN) begin
          // Position stays at the last committed placement for the merge stage.
          lock_nxt   = 1'b1;
          active_nxt = 1'b0;
          state_nxt  = IDLE;
        end else if (op == OP_SPAWN) begin
          spawn_fail_nxt = 1'b1;
          state_nxt      = IDLE;
        end else begin
          state_nxt = READY;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: doc/piece_mover.md
# piece_mover

Active-piece movement controller that sits directly upstream of the collision checker. It holds the committed position and 4x4 pattern of the falling tetromino and turns spawn and move commands into candidate placements. It presents each candidate to the checker, waits for the registered verdict, then commits or rejects the move. A rejected downward move raises a lock pulse for the downstream merge/line-clear stage.

## Interface
No parameters; board is fixed at 10 columns x 20 rows, static index = row*10 + col, row 0 = bottom.
- clk  in  1  system clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- spawn  in  1  pulse; load a new piece (honoured only in IDLE)
- spawn_pattern  in  [0:15]  4x4 pattern, bit r*4+c, r=0 bottom row, c=0 left column
- spawn_x  in  4  anchor column (rightmost column of the 4x4 box)
- spawn_y  in  5  anchor row (top row of the 4x4 box)
- cmd_valid  in  1  move command valid
- cmd_ready  out  1  high only in READY
- cmd  in  2  00 left, 01 right, 10 down, 11 rotate clockwise
- chk_x  out  4  candidate anchor column to checker
- chk_y  out  5  candidate anchor row to checker
- chk_float  out  [0:15]  candidate pattern to checker
- collision  in  1  checker verdict, registered inside checker (1-cycle latency)
- pos_x  out  4  committed anchor column
- pos_y  out  5  committed anchor row
- float  out  [0:15]  committed pattern
- active  out  1  a piece is in play
- move_done  out  1  1-cycle pulse, a command or spawn finished evaluation
- move_ok  out  1  valid with move_done; 1 = committed
- lock  out  1  1-cycle pulse, down move rejected, piece must merge
- spawn_fail  out  1  1-cycle pulse, spawn placement collides (game over)

## Operation
- States: IDLE, READY, CHECK, EVAL.
- IDLE: active=0. On spawn, drive chk_* from spawn_*, remember op=SPAWN, go to CHECK.
- READY: active=1, cmd_ready=1. On cmd_valid, build the candidate, drive chk_*, latch op=cmd, go to CHECK. spawn is ignored.
- Candidates:
  - left: chk_x = pos_x - 1, 4-bit wrap; 0 gives 15, which the checker rejects.
  - right: chk_x = pos_x + 1.
  - down: chk_y = pos_y - 1, 5-bit wrap; 0 gives 31, which the checker treats as bottom collision.
  - rotate: same position, chk_float[r*4+c] = float[c*4 + (3-r)].
  - Unchanged coordinates copy the committed values.
- CHECK: one cycle, no action; the checker samples chk_* on this edge.
- EVAL: sample collision.
  - collision=0: copy chk_* into pos_x/pos_y/float, move_ok=1. A SPAWN sets active=1. Go to READY.
  - collision=1, op=down: lock pulse, active=0, go to IDLE. pos/float keep their last committed values for the merge stage.
  - collision=1, op=SPAWN: spawn_fail pulse, go to IDLE.
  - collision=1, other ops: discard, move_ok=0, go to READY.
  - move_done pulses in every EVAL.
- Environment requirement: the static board must not change between command acceptance and EVAL. The merge stage only writes in IDLE, after lock.
- chk_* hold their last value outside a check.

## Timing
- Reset: state IDLE. Outputs pos_x=0, pos_y=0, float=0, chk_*=0, active=0, cmd_ready=0, move_done=0, move_ok=0, lock=0, spawn_fail=0.
- Command accepted on edge A (cmd_valid & cmd_ready): chk_* valid after A; the checker registers on A+1.
- On edge A+2 (EVAL), the commit happens and the pulses assert for the cycle after A+2. cmd_ready returns in that same cycle.
- Throughput: one command per 3 cycles. Spawn has the same latency.
- cmd_valid held high is consumed once per READY visit; there is no queueing.
- rst during CHECK/EVAL abandons the check. No pulse is produced.
- spawn and cmd_valid together in IDLE: spawn wins; cmd_ready=0 so cmd is not taken.

## Test plan
- Reset, then spawn pattern 0x0F00 (bits 4..7 set) at x=5, y=19, collision held 0 -> move_done+move_ok three cycles after spawn, active=1, pos=(5,19), float=spawn_pattern.
- From pos (5,19), cmd=left, collision=0 -> chk_x=4 one cycle after accept, pos_x=4 after EVAL, cmd_ready back 3 cycles after accept.
- From pos_x=0, cmd=left with collision=1 in EVAL -> chk_x=15, move_ok=0, pos_x stays 0, state READY, no lock.
- From pos_y=0, cmd=down, collision=1 -> chk_y=31, lock pulse one cycle, active=0, pos_y stays 0, cmd_ready=0.
- Rotate float with only bit 12 set (top-left) -> chk_float has only bit 15 set; commit on collision=0.
- Spawn with collision=1 -> spawn_fail pulse, active stays 0. Separately, assert rst in CHECK -> IDLE next cycle, all outputs at reset values, no move_done.
